// File: rtl/d16_uart_if.sv
// Data-bus bundle between the d16 core (master) and a memory-mapped peripheral (slave).
// Read data is combinational from the slave within the same cycle.
interface d16_uart_if;
    logic [15:0] wb_addr;
    logic        wb_cyc;
    logic        wb_we;
    logic [15:0] wb_dat_w;
    logic [15:0] wb_dat_r;

    modport master (output wb_addr, output wb_cyc, output wb_we, output wb_dat_w, input  wb_dat_r);
    modport slave  (input  wb_addr, input  wb_cyc, input  wb_we, input  wb_dat_w, output wb_dat_r);
endinterface

// File: rtl/d16_uart.sv
// d16_uart: memory-mapped 8N1 UART with TX/RX byte FIFOs, programmable divisor and a level IRQ.
// Four-word window: +0 DATA, +1 STATUS, +2 DIV, +3 CTRL.
module d16_uart_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_push,
    input  logic [7:0] i_din,
    input  logic       i_pop,
    output logic [7:0] o_dout,
    output logic       o_empty,
    output logic       o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s, do_pop_s;

    assign o_empty   = (count_r == {(AW+1){1'b0}});
    assign o_full    = (count_r == CNT_FULL);
    assign do_pop_s  = i_pop && !o_empty;
    assign do_push_s = i_push && (!o_full || do_pop_s);
    assign o_dout    = mem_r[rd_ptr_r];

    // storage array, written on an accepted push
    always_ff @(posedge i_clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= i_din;
        end
    end

    // pointers wrap naturally because the depth is a power of two
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

module d16_uart #(
    parameter logic [15:0] BASE       = 16'hFF00,
    parameter logic [15:0] DIV_RESET  = 16'd103,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    d16_uart_if.slave     bus,
    input  logic          i_rx,
    output logic          o_tx,
    output logic          o_int
);
    typedef enum logic [1:0] {TIDLE, TSTART, TDATA, TSTOP} tx_state_t;
    typedef enum logic [2:0] {RIDLE, RSTART, RDATA, RSTOP, RBREAK} rx_state_t;

    logic        hit_s, rd_s, wr_s, stat_rd_s;
    logic [1:0]  reg_s;
    logic [15:0] div_r, div_eff_s, rdata_s;
    logic [1:0]  ctrl_r;
    logic        ovr_r, fe_r, int_r, ovr_set_s, tx_idle_s;
    logic [7:0]  tx_head_s, rx_head_s;
    logic        tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;

    tx_state_t   tx_state_r, tx_next_s;
    logic [15:0] tx_cnt_r;
    logic [2:0]  tx_bit_r;
    logic [7:0]  tx_shift_r;
    logic        tx_r, tx_pop_s, tx_expire_s;

    rx_state_t   rx_state_r, rx_next_s;
    logic [15:0] rx_cnt_r;
    logic [2:0]  rx_bit_r;
    logic [7:0]  rx_shift_r;
    logic        rx_meta_r, rx_sync_r, rx_push_s, rx_pop_s, fe_set_s, rx_expire_s;

    assign hit_s     = bus.wb_cyc && (bus.wb_addr[15:2] == BASE[15:2]);
    assign rd_s      = hit_s && !bus.wb_we;
    assign wr_s      = hit_s && bus.wb_we;
    assign reg_s     = bus.wb_addr[1:0];
    assign stat_rd_s = rd_s && (reg_s == 2'd1);
    assign div_eff_s = (div_r < 16'd2) ? 16'd2 : div_r;
    assign tx_idle_s = tx_empty_s && (tx_state_r == TIDLE);
    assign rx_pop_s  = rd_s && (reg_s == 2'd0) && !rx_empty_s;
    assign ovr_set_s = rx_push_s && rx_full_s && !rx_pop_s;
    assign o_tx      = tx_r;
    assign o_int     = int_r;
    assign bus.wb_dat_r = rdata_s;

    d16_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_push(wr_s && (reg_s == 2'd0)), .i_din(bus.wb_dat_w[7:0]), .i_pop(tx_pop_s),
        .o_dout(tx_head_s), .o_empty(tx_empty_s), .o_full(tx_full_s)
    );

    d16_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_push(rx_push_s), .i_din(rx_shift_r), .i_pop(rx_pop_s),
        .o_dout(rx_head_s), .o_empty(rx_empty_s), .o_full(rx_full_s)
    );

    // combinational register read mux; zero outside the window
    always_comb begin
        rdata_s = 16'd0;
        if (rd_s) begin
            case (reg_s)
                2'd0:    rdata_s = rx_empty_s ? 16'd0 : {8'd0, rx_head_s};
                2'd1:    rdata_s = {11'd0, fe_r, ovr_r, tx_idle_s, tx_full_s, !rx_empty_s};
                2'd2:    rdata_s = div_r;
                2'd3:    rdata_s = {14'd0, ctrl_r};
                default: rdata_s = 16'd0;
            endcase
        end else begin
            rdata_s = 16'd0;
        end
    end

    // control registers, sticky error flags and the interrupt line
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            div_r  <= DIV_RESET;
            ctrl_r <= 2'b00;
            ovr_r  <= 1'b0;
            fe_r   <= 1'b0;
            int_r  <= 1'b0;
        end else begin
            if (wr_s && (reg_s == 2'd2)) div_r  <= bus.wb_dat_w;
            if (wr_s && (reg_s == 2'd3)) ctrl_r <= bus.wb_dat_w[1:0];
            ovr_r <= ovr_set_s ? 1'b1 : (stat_rd_s ? 1'b0 : ovr_r);
            fe_r  <= fe_set_s  ? 1'b1 : (stat_rd_s ? 1'b0 : fe_r);
            int_r <= (ctrl_r[0] && !rx_empty_s) || (ctrl_r[1] && tx_idle_s);
        end
    end

    // TX next-state: a pop at TIDLE or end of TSTOP starts the next frame with no gap
    always_comb begin
        tx_next_s   = tx_state_r;
        tx_pop_s    = 1'b0;
        tx_expire_s = (tx_cnt_r == 16'd0);
        case (tx_state_r)
            TIDLE: begin
                if (!tx_empty_s) begin
                    tx_pop_s  = 1'b1;
                    tx_next_s = TSTART;
                end else begin
                    tx_next_s = TIDLE;
                end
            end
            TSTART: begin
                if (tx_expire_s) tx_next_s = TDATA;
                else             tx_next_s = TSTART;
            end
            TDATA: begin
                if (tx_expire_s && (tx_bit_r == 3'd7)) tx_next_s = TSTOP;
                else                                   tx_next_s = TDATA;
            end
            TSTOP: begin
                if (tx_expire_s && !tx_empty_s) begin
                    tx_pop_s  = 1'b1;
                    tx_next_s = TSTART;
                end else if (tx_expire_s) begin
                    tx_next_s = TIDLE;
                end else begin
                    tx_next_s = TSTOP;
                end
            end
            default: tx_next_s = TIDLE;
        endcase
    end

    // TX datapath; the divisor is only sampled on a counter reload
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tx_state_r <= TIDLE;
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'd0;
            tx_r       <= 1'b1;
        end else begin
            tx_state_r <= tx_next_s;
            if (tx_pop_s) begin
                tx_shift_r <= tx_head_s;
                tx_cnt_r   <= div_eff_s;
                tx_bit_r   <= 3'd0;
                tx_r       <= 1'b0;
            end else if (tx_state_r == TIDLE) begin
                tx_r <= 1'b1;
            end else if (tx_expire_s) begin
                tx_cnt_r <= div_eff_s;
                case (tx_state_r)
                    TSTART: tx_r <= tx_shift_r[0];
                    TDATA: begin
                        if (tx_bit_r == 3'd7) begin
                            tx_r <= 1'b1;
                        end else begin
                            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                            tx_r       <= tx_shift_r[1];
                            tx_bit_r   <= tx_bit_r + 3'd1;
                        end
                    end
                    default: tx_r <= 1'b1;
                endcase
            end else begin
                tx_cnt_r <= tx_cnt_r - 16'd1;
            end
        end
    end

    // RX next-state; RBREAK holds off after a framing error until the line returns high
    always_comb begin
        rx_next_s   = rx_state_r;
        rx_push_s   = 1'b0;
        fe_set_s    = 1'b0;
        rx_expire_s = (rx_cnt_r == 16'd0);
        case (rx_state_r)
            RIDLE: begin
                if (!rx_sync_r) rx_next_s = RSTART;
                else            rx_next_s = RIDLE;
            end
            RSTART: begin
                if (rx_expire_s) rx_next_s = rx_sync_r ? RIDLE : RDATA;
                else             rx_next_s = RSTART;
            end
            RDATA: begin
                if (rx_expire_s && (rx_bit_r == 3'd7)) rx_next_s = RSTOP;
                else                                   rx_next_s = RDATA;
            end
            RSTOP: begin
                if (rx_expire_s && rx_sync_r) begin
                    rx_push_s = 1'b1;
                    rx_next_s = RIDLE;
                end else if (rx_expire_s) begin
                    fe_set_s  = 1'b1;
                    rx_next_s = RBREAK;
                end else begin
                    rx_next_s = RSTOP;
                end
            end
            RBREAK: begin
                if (rx_sync_r) rx_next_s = RIDLE;
                else           rx_next_s = RBREAK;
            end
            default: rx_next_s = RIDLE;
        endcase
    end

    // RX synchroniser, half-bit start qualification and LSB-first shift-in
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta_r  <= 1'b1;
            rx_sync_r  <= 1'b1;
            rx_state_r <= RIDLE;
            rx_cnt_r   <= 16'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'd0;
        end else begin
            rx_meta_r  <= i_rx;
            rx_sync_r  <= rx_meta_r;
            rx_state_r <= rx_next_s;
            case (rx_state_r)
                RIDLE: begin
                    rx_cnt_r <= {1'b0, div_eff_s[15:1]};
                    rx_bit_r <= 3'd0;
                end
                RSTART, RSTOP: begin
                    rx_cnt_r <= rx_expire_s ? div_eff_s : (rx_cnt_r - 16'd1);
                end
                RDATA: begin
                    if (rx_expire_s) begin
                        rx_cnt_r   <= div_eff_s;
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        rx_bit_r   <= rx_bit_r + 3'd1;
                    end else begin
                        rx_cnt_r <= rx_cnt_r - 16'd1;
                    end
                end
                default: rx_cnt_r <= rx_cnt_r;
            endcase
        end
    end
endmodule
